// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage RV64 core.
//
// It captures the decode-stage control word, operands and register indices
// and presents them to EX one cycle later. It also holds the load-use hazard
// detector: that logic drives the PC and IF/ID write enables, inserts bubbles
// and applies branch flushes. Two saturating counters record stall and flush
// events.
//
// Ports
//   clk, reset            core clock; synchronous active-high reset
//   id_*                  decoded instruction from ID (control, data, indices)
//   ex_branch_taken       branch in EX resolved taken -> flush
//   ex_hold               EX cannot accept a new instruction -> freeze
//   ex_*                  registered copy of the ID fields presented to EX
//   pc_write_en           PC may advance (combinational)
//   if_id_write_en        IF/ID may load (combinational)
//   if_id_flush           IF/ID must become a bubble (combinational)
//   stall_cnt, flush_cnt  saturating event counters
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic [1:0]       id_alu_op,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_funct,
    input  logic             ex_branch_taken,
    input  logic             ex_hold,
    output logic             ex_valid,
    output logic             ex_branch,
    output logic             ex_mem_read,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic [1:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // All ID/EX fields travel as one packed word, so a bubble is a single clear.
    localparam int W = 28 + 4 * XLEN;

    logic [W-1:0]     stage_q, stage_d;
    logic [W-1:0]     id_word_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             uses_rs1_s, uses_rs2_s, load_use_s;

    // Saturating increment: hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign id_word_s = {id_valid, id_branch, id_mem_read, id_mem_to_reg,
                        id_mem_write, id_alu_src, id_reg_write, id_alu_op,
                        id_pc, id_rs1_data, id_rs2_data, id_imm,
                        id_rs1, id_rs2, id_rd, id_funct};

    assign {ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg,
            ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
            ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
            ex_rs1, ex_rs2, ex_rd, ex_funct} = stage_q;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Hazard detection: a valid load in EX whose rd feeds an operand that the
    // ID instruction actually reads. Loads to x0 never stall.
    always_comb begin
        uses_rs1_s = id_valid & (id_reg_write | id_mem_read | id_mem_write | id_branch);
        uses_rs2_s = id_valid & (~id_alu_src | id_mem_write);
        load_use_s = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                     ((uses_rs1_s & (ex_rd == id_rs1)) |
                      (uses_rs2_s & (ex_rd == id_rs2)));
    end

    // Per-cycle action, in priority order: hold, flush, load-use stall, advance.
    // Reset is applied in the register process and overrides all of these.
    always_comb begin
        stage_d        = stage_q;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        if (ex_hold) begin
            // A taken branch during a hold is dropped; EX re-asserts it later.
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
        end else if (ex_branch_taken) begin
            stage_d     = {W{1'b0}};
            if_id_flush = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (load_use_s) begin
            // The consumer stays in ID and retries once the load is in MEM.
            stage_d        = {W{1'b0}};
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            stall_cnt_d    = sat_inc(stall_cnt_q);
        end else begin
            stage_d = id_word_s;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q     <= {W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the ID/EX slot.
module tb_id_ex_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic            valid;
        logic            branch;
        logic            mem_read;
        logic            mem_to_reg;
        logic            mem_write;
        logic            alu_src;
        logic            reg_write;
        logic [1:0]      alu_op;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
    } instr_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   bt_s, hold_s;
    instr_t id_s;

    logic             ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic             ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]       ex_alu_op;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_funct;
    logic             pc_write_en, if_id_write_en, if_id_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Model state: what the ID/EX slot should hold, and the event counts.
    instr_t m_ex;
    int     m_stall, m_flush;
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_s.valid), .id_branch(id_s.branch),
        .id_mem_read(id_s.mem_read), .id_mem_to_reg(id_s.mem_to_reg),
        .id_mem_write(id_s.mem_write), .id_alu_src(id_s.alu_src),
        .id_reg_write(id_s.reg_write), .id_alu_op(id_s.alu_op),
        .id_pc(id_s.pc), .id_rs1_data(id_s.rs1_data),
        .id_rs2_data(id_s.rs2_data), .id_imm(id_s.imm),
        .id_rs1(id_s.rs1), .id_rs2(id_s.rs2), .id_rd(id_s.rd),
        .id_funct(id_s.funct),
        .ex_branch_taken(bt_s), .ex_hold(hold_s),
        .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct(ex_funct),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .if_id_flush(if_id_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic instr_t base(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        instr_t t;
        t          = '0;
        t.valid    = 1'b1;
        t.pc       = rnd64();
        t.rs1_data = rnd64();
        t.rs2_data = rnd64();
        t.imm      = rnd64();
        t.rs1      = rs1;
        t.rs2      = rs2;
        t.rd       = rd;
        t.funct    = 4'($urandom);
        return t;
    endfunction

    function automatic instr_t op_ld(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t t = base(rs1, 5'd0, rd);
        t.mem_read = 1'b1; t.mem_to_reg = 1'b1; t.alu_src = 1'b1; t.reg_write = 1'b1;
        return t;
    endfunction

    function automatic instr_t op_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f);
        instr_t t = base(rs1, rs2f, rd);
        t.alu_src = 1'b1; t.reg_write = 1'b1; t.alu_op = 2'b10;
        return t;
    endfunction

    function automatic instr_t op_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t t = base(rs1, rs2, rd);
        t.reg_write = 1'b1; t.alu_op = 2'b10;
        return t;
    endfunction

    function automatic instr_t op_sd(input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t t = base(rs1, rs2, 5'd0);
        t.mem_write = 1'b1; t.alu_src = 1'b1;
        return t;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t t = base(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        t.valid      = ($urandom_range(0, 9) != 0);
        t.branch     = 1'($urandom);
        t.mem_read   = 1'($urandom);
        t.mem_to_reg = 1'($urandom);
        t.mem_write  = 1'($urandom);
        t.alu_src    = 1'($urandom);
        t.reg_write  = 1'($urandom);
        t.alu_op     = 2'($urandom);
        return t;
    endfunction

    // One clock cycle: check the registered state, apply inputs, check the
    // enables, then advance the model to what the next edge should produce.
    task automatic cycle(input instr_t id, input logic bt, input logic hold, input logic rst);
        logic u1, u2, lu;
        logic e_pc, e_ifid, e_fl;
        @(negedge clk);
        check("ex_word", {ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg,
                          ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
                          ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                          ex_rs1, ex_rs2, ex_rd, ex_funct}, 300'(m_ex));
        check("stall_cnt", 300'(stall_cnt), 300'(m_stall));
        check("flush_cnt", 300'(flush_cnt), 300'(m_flush));
        id_s   = id;
        bt_s   = bt;
        hold_s = hold;
        reset  = rst;
        #1;
        u1 = id.valid & (id.reg_write | id.mem_read | id.mem_write | id.branch);
        u2 = id.valid & (~id.alu_src | id.mem_write);
        lu = m_ex.valid && m_ex.mem_read && (m_ex.rd != 5'd0) &&
             ((u1 && m_ex.rd == id.rs1) || (u2 && m_ex.rd == id.rs2));
        if (hold) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_fl = 1'b0;
        end else if (bt) begin
            e_pc = 1'b1; e_ifid = 1'b1; e_fl = 1'b1;
        end else if (lu) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_fl = 1'b0;
        end else begin
            e_pc = 1'b1; e_ifid = 1'b1; e_fl = 1'b0;
        end
        check("enables", 300'({pc_write_en, if_id_write_en, if_id_flush}), 300'({e_pc, e_ifid, e_fl}));
        if (rst) begin
            m_ex = '0; m_stall = 0; m_flush = 0;
        end else if (hold) begin
            m_ex = m_ex;
        end else if (bt) begin
            m_ex = '0;
            if (m_flush < CMAX) m_flush++;
        end else if (lu) begin
            m_ex = '0;
            if (m_stall < CMAX) m_stall++;
        end else begin
            m_ex = id;
        end
    endtask

    task automatic run(input instr_t id);
        cycle(id, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        instr_t addi7;
        id_s   = '0;
        bt_s   = 1'b0;
        hold_s = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        m_ex = '0; m_stall = 0; m_flush = 0;
        cycle('0, 1'b0, 1'b0, 1'b1);

        // Pass-through of an R-type
        begin
            instr_t r = op_add(5'd5, 5'd3, 5'd4);
            r.pc = 64'h100;
            run(r);
        end
        run('0);

        // Load-use on rs1, then the stalled addi re-presented
        run(op_ld(5'd7, 5'd1));
        addi7 = op_addi(5'd8, 5'd7, 5'd0);
        run(addi7);
        run(addi7);
        run('0);

        // Non-hazards and the store-data hazard
        run(op_ld(5'd0, 5'd1));
        run(op_add(5'd2, 5'd0, 5'd3));
        run(op_ld(5'd9, 5'd1));
        run(op_addi(5'd2, 5'd1, 5'd9));
        run(op_ld(5'd9, 5'd1));
        run(op_sd(5'd2, 5'd9));
        run('0);

        // Flush beats load-use
        run(op_ld(5'd7, 5'd1));
        cycle(op_addi(5'd8, 5'd7, 5'd0), 1'b1, 1'b0, 1'b0);
        run('0);

        // Hold for three cycles with a taken branch and a new ID instruction
        run(op_add(5'd6, 5'd1, 5'd2));
        repeat (3) cycle(op_add(5'd10, 5'd11, 5'd12), 1'b1, 1'b1, 1'b0);
        run('0);

        // Saturation of the stall counter
        repeat (5) begin
            run(op_ld(5'd7, 5'd1));
            run(op_addi(5'd8, 5'd7, 5'd0));
        end
        run('0);
        check("stall_sat", 300'(stall_cnt), 300'(CMAX));

        // Reset during a stall
        run(op_ld(5'd7, 5'd1));
        cycle(op_addi(5'd8, 5'd7, 5'd0), 1'b0, 1'b0, 1'b1);
        run('0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(rnd_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 49) == 0));
        end
        run('0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
